// File: rtl/hs_fifo_if.sv
// Valid/ready bundle between the upstream receiver, the FIFO and the downstream sender.
// The master modport is the side that offers write data and consumes read data.
interface hs_fifo_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   count;
  logic          almost_full;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count, almost_full
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count, almost_full
  );
endinterface

// File: rtl/hs_fifo.sv
// First-word-fall-through valid/ready FIFO with wrap-bit pointers and a registered occupancy count.
// Status outputs derive from registered state only, so no input reaches an output combinationally.
module hs_fifo #(
  parameter int DW          = 8,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input logic       clk,
  input logic       rst_n,
  hs_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AFULL_THRESH = (AW + 1)'(AFULL_LEVEL);
  localparam logic [AW:0] ONE          = (AW + 1)'(1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wrPtr;
  logic [AW:0]   r_rdPtr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Equal index with differing wrap bits means the writer is a full lap ahead.
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]) && (r_wrPtr[AW] != r_rdPtr[AW]);
  assign w_push  = bus.in_valid && !w_full;
  assign w_pop   = bus.out_ready && !w_empty;

  assign bus.in_ready    = !w_full;
  assign bus.out_valid   = !w_empty;
  assign bus.out_data    = r_mem[r_rdPtr[AW-1:0]];
  assign bus.count       = r_count;
  assign bus.almost_full = (r_count >= AFULL_THRESH);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr[AW-1:0]] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - ONE;
      end
    end
  end
endmodule

// File: tb/tb_hs_fifo.sv
// Bench for hs_fifo: a queue-based reference model checked every negative edge, plus directed
// scenarios for fill, drain, simultaneous traffic, full-with-pop, reset and a randomized stream.
module tb_hs_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [DW-1:0] expQ [$];
  logic          holdPrev = 1'b0;
  logic [DW-1:0] holdData = '0;

  hs_fifo_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  hs_fifo #(
    .DW          (DW),
    .DEPTH       (DEPTH),
    .AFULL_LEVEL (AFULL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: inputs change just after a rising edge and hold until the next one.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // The model is a plain queue of accepted words; the handshakes it predicts happen at the next rising edge.
  always @(negedge clk) begin
    logic modelReady;
    if (!rst_n) begin
      expQ.delete();
      holdPrev = 1'b0;
    end else begin
      modelReady = (expQ.size() < DEPTH);
      checkOutput("mon_out_valid", 32'(bus.out_valid), 32'(expQ.size() != 0));
      checkOutput("mon_in_ready", 32'(bus.in_ready), 32'(modelReady));
      checkOutput("mon_count", 32'(bus.count), 32'(expQ.size()));
      checkOutput("mon_almost_full", 32'(bus.almost_full), 32'(expQ.size() >= AFULL));
      if (holdPrev) begin
        checkOutput("mon_hold_stable", 32'(bus.out_data), 32'(holdData));
      end
      if (expQ.size() != 0) begin
        checkOutput("mon_out_data", 32'(bus.out_data), 32'(expQ[0]));
        holdPrev = !bus.out_ready;
        holdData = expQ[0];
        if (bus.out_ready) begin
          void'(expQ.pop_front());
          pops++;
        end
      end else begin
        holdPrev = 1'b0;
      end
      if (bus.in_valid && modelReady) begin
        expQ.push_back(bus.in_data);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx;
    int popsBefore;
    logic acc;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_count", 32'(bus.count), 32'd0);
    checkOutput("rst_almost_full", 32'(bus.almost_full), 32'd0);
    rst_n = 1'b1;

    // Fill to full, then offer a fifth word that must be refused.
    applyStimulus(1'b1, 8'h01, 1'b0);
    checkOutput("fill1_count", 32'(bus.count), 32'd1);
    checkOutput("fill1_out_data", 32'(bus.out_data), 32'h01);
    applyStimulus(1'b1, 8'h02, 1'b0);
    checkOutput("fill2_count", 32'(bus.count), 32'd2);
    checkOutput("fill2_afull", 32'(bus.almost_full), 32'd0);
    applyStimulus(1'b1, 8'h03, 1'b0);
    checkOutput("fill3_count", 32'(bus.count), 32'd3);
    checkOutput("fill3_afull", 32'(bus.almost_full), 32'd1);
    checkOutput("fill3_in_ready", 32'(bus.in_ready), 32'd1);
    applyStimulus(1'b1, 8'h04, 1'b0);
    checkOutput("fill4_count", 32'(bus.count), 32'd4);
    checkOutput("fill4_in_ready", 32'(bus.in_ready), 32'd0);
    applyStimulus(1'b1, 8'h05, 1'b0);
    checkOutput("full_reject_count", 32'(bus.count), 32'd4);
    checkOutput("full_reject_head", 32'(bus.out_data), 32'h01);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_data", 32'(bus.out_data), 32'(i + 1));
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checkOutput("drain_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("drain_count", 32'(bus.count), 32'd0);

    // Simultaneous push and pop at occupancy 2.
    applyStimulus(1'b1, 8'h10, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b0);
    checkOutput("simul_pre_count", 32'(bus.count), 32'd2);
    applyStimulus(1'b1, 8'h12, 1'b1);
    checkOutput("simul_count", 32'(bus.count), 32'd2);
    checkOutput("simul_head", 32'(bus.out_data), 32'h11);

    // Full with a pop: only the pop happens, the held word goes in on the following edge.
    applyStimulus(1'b1, 8'h13, 1'b0);
    applyStimulus(1'b1, 8'h14, 1'b0);
    checkOutput("fullpop_pre_count", 32'(bus.count), 32'd4);
    applyStimulus(1'b1, 8'h15, 1'b1);
    checkOutput("fullpop_count", 32'(bus.count), 32'd3);
    checkOutput("fullpop_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("fullpop_head", 32'(bus.out_data), 32'h12);
    applyStimulus(1'b1, 8'h15, 1'b0);
    checkOutput("fullpop_accept_count", 32'(bus.count), 32'd4);

    // Asynchronous reset mid-stream at occupancy 2.
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("midrst_pre_count", 32'(bus.count), 32'd2);
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("midrst_count", 32'(bus.count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 8'hA5, 1'b0);
    checkOutput("postrst_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("postrst_out_data", 32'(bus.out_data), 32'hA5);
    checkOutput("postrst_count", 32'(bus.count), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("postrst_empty", 32'(bus.out_valid), 32'd0);

    // Randomized stream of 20 incrementing bytes with random backpressure on both sides.
    popsBefore = pops;
    idx = 0;
    for (int cyc = 0; cyc < 2000 && idx < 20; cyc++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 8'(8'h40 + idx);
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      #1 acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    checkOutput("rand_all_sent", 32'(idx), 32'd20);
    for (int cyc = 0; cyc < 40 && expQ.size() != 0; cyc++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checkOutput("rand_all_received", 32'(pops - popsBefore), 32'd20);
    checkOutput("rand_model_empty", 32'(expQ.size()), 32'd0);
    checkOutput("rand_final_count", 32'(bus.count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hs_fifo.md
# hs_fifo

Synchronous valid/ready FIFO that sits between the handshake receiver and the handshake sender. It accepts words from the upstream receiver side, buffers up to DEPTH of them, and presents them first-word-fall-through to the downstream sender. Its non-empty status (out_valid) is the sender's "have data" state, and its non-full status (in_ready) is the receiver's "may accept" state. Both ends use the same clock.

## Interface
- DW, 8, data word width in bits (≥1)
- DEPTH, 4, storage depth in words; power of two, ≥2
- AW, log2(DEPTH), derived pointer index width; not overridden
- AFULL_LEVEL, DEPTH-1, occupancy at or above which almost_full asserts (1..DEPTH)
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- in_data  input  DW  write word
- in_valid  input  1  upstream offers in_data this cycle
- in_ready  output  1  FIFO can accept a word this cycle
- out_data  output  DW  head-of-queue word, valid when out_valid=1
- out_valid  output  1  FIFO holds at least one word
- out_ready  input  1  downstream consumes out_data this cycle
- count  output  AW+1  current occupancy, 0..DEPTH
- almost_full  output  1  count ≥ AFULL_LEVEL

## Operation
- Push: in_valid && in_ready at a rising edge writes in_data to mem[wr_ptr] and increments wr_ptr.
- Pop: out_valid && out_ready at a rising edge increments rd_ptr.
- Pointers are AW+1 bits; the low AW bits index mem and the MSB is the wrap bit. Pointers wrap modulo 2·DEPTH.
- empty when wr_ptr == rd_ptr. full when the low AW bits are equal and the MSBs differ.
- count is a registered counter: +1 on push only, -1 on pop only, unchanged on both or neither.
- Status outputs:
  - in_ready = !full. It is a function of registered state only and never depends on in_valid or out_ready.
  - out_valid = !empty.
  - out_data = mem[rd_ptr[AW-1:0]], a combinational read of the array (first-word-fall-through).
- Full: in_ready=0, so in_valid is ignored even if a pop occurs the same cycle. There is no full-bypass; in_ready rises the cycle after the pop.
- Empty: out_valid=0 and out_ready is ignored. There is no empty-bypass; a pushed word appears on out_data the cycle after the push edge.
- Simultaneous push and pop, neither full nor empty: both pointers advance and count is unchanged.
- Data contract: out_data and out_valid are stable while out_valid=1 && out_ready=0. Words leave in exactly the order accepted, with no loss and no duplication.
- Reset (rst=0, asynchronous):
  - wr_ptr, rd_ptr and count go to 0 immediately.
  - Resulting outputs: out_valid=0, in_ready=1, count=0, almost_full=0 (almost_full is 1 only if AFULL_LEVEL=0, which is disallowed).
  - mem is not reset, so out_data is don't-care while out_valid=0.
  - Reset mid-operation discards all stored words. No handshake completes on the edge where rst is low.
- Release: the first push can be accepted on the first rising edge with rst=1.

## Timing
- Push-to-output latency: 1 cycle. A word accepted at edge N is visible on out_data/out_valid after edge N when the FIFO was empty.
- Pop-to-ready latency when full: 1 cycle. A pop at edge N makes in_ready=1 after edge N.
- count and almost_full update after each edge. almost_full is combinational from registered count.
- Throughput: 1 push and 1 pop per cycle sustained when 0<count<DEPTH.
- No combinational path from in_valid to in_ready or from out_ready to out_valid. The only input-to-output combinational path is none; out_data depends on rd_ptr and mem only.

## Test plan
(DW=8, DEPTH=4, AFULL_LEVEL=3 unless noted)
- Reset check: assert rst=0 mid-stream with count=2 → immediately out_valid=0, in_ready=1, count=0. After release, push 0xA5 → out_data=0xA5 and out_valid=1 one cycle later.
- Fill to full: push 0x01,0x02,0x03,0x04 with out_ready=0 → count 1,2,3,4; almost_full rises at count=3; in_ready=0 at count=4. A fifth word 0x05 held valid is not accepted and count stays 4.
- Drain and order: from full, out_ready=1 for 4 cycles → out_data 0x01,0x02,0x03,0x04 in order; out_valid=0 after the 4th pop; count=0.
- Simultaneous push/pop at count=2: one edge with both handshakes → count stays 2, pointers advance, head becomes the next older word.
- Full-with-pop: at count=4, in_valid=1 and out_ready=1 → only the pop occurs (count=3). in_ready=1 next cycle, and the held word is accepted then.
- Wrap-around and backpressure: stream 20 incrementing bytes with random in_valid/out_ready → scoreboard matches all 20 in order across ≥2 pointer wraps. out_data is stable whenever out_valid=1 && out_ready=0.
